// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC phase extractor.
//   - FSM state encoding
//   - datapath widths (input 17, internal 20, phase 16, magnitude 18)
//   - atan(2^-i) table in 0..65535-per-turn units
//   - saturating absolute value used when folding into the first quadrant
package cordic_pkg;

    localparam int IN_W  = 17;
    localparam int DP_W  = 20;
    localparam int PH_W  = 16;
    localparam int MAG_W = 18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // round(atan(2^-i) * 65536 / (2*pi))
    function automatic logic [PH_W-1:0] atan_lut(input logic [3:0] idx);
        logic [PH_W-1:0] v;
        case (idx)
            4'd0:    v = 16'd8192;
            4'd1:    v = 16'd4836;
            4'd2:    v = 16'd2555;
            4'd3:    v = 16'd1297;
            4'd4:    v = 16'd651;
            4'd5:    v = 16'd326;
            4'd6:    v = 16'd163;
            4'd7:    v = 16'd81;
            4'd8:    v = 16'd41;
            4'd9:    v = 16'd20;
            4'd10:   v = 16'd10;
            4'd11:   v = 16'd5;
            4'd12:   v = 16'd3;
            4'd13:   v = 16'd1;
            4'd14:   v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // |v| for a sign-extended 17-bit sample; -65536 has no positive
    // 17-bit twin, so it is pinned to 65535.
    function automatic logic signed [DP_W-1:0] sat_abs(input logic signed [DP_W-1:0] v);
        logic signed [DP_W-1:0] r;
        if (v == -20'sd65536)
            r = 20'sd65535;
        else if (v < 0)
            r = -v;
        else
            r = v;
        return r;
    endfunction

endpackage

// File: rtl/atan_rom.sv
// Combinational atan lookup for the CORDIC iteration index.
//   idx_i  : iteration number 0..15
//   atan_o : atan(2^-idx) in phase units (65536 per turn)
module atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]      idx_i,
    output logic [PH_W-1:0] atan_o
);

    assign atan_o = atan_lut(idx_i);

endmodule

// File: rtl/phase_extract.sv
// Iterative CORDIC vectoring engine: converts an (x, y) sample into an
// unsigned 16-bit phase (0..65535 = 0..2pi) and a gain-scaled magnitude.
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : start pulse, only looked at while idle
//   x_in, y_in     : signed 17-bit I/Q sample
//   busy           : computation in flight (through the finish cycle)
//   finish_phase   : one-cycle result strobe
//   phase_out      : phase result, held until the next result
//   mag_out        : ~1.6468*sqrt(x^2+y^2), held until the next result
module phase_extract
    import cordic_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic signed [IN_W-1:0] x_in,
    input  logic signed [IN_W-1:0] y_in,
    output logic                   busy,
    output logic                   finish_phase,
    output logic [PH_W-1:0]        phase_out,
    output logic [MAG_W-1:0]       mag_out
);

    state_e                 state_q;
    logic signed [DP_W-1:0] x_q, y_q, z_q;
    logic [3:0]             cnt_q;
    logic                   qx_q, qy_q;      // original signs of x and y
    logic                   busy_q, fin_q;
    logic [PH_W-1:0]        phase_q;
    logic [MAG_W-1:0]       mag_q;

    logic [PH_W-1:0]        atan_w;
    logic signed [DP_W-1:0] atan_ext, x_sh, y_sh;
    logic signed [DP_W-1:0] x_it_d, y_it_d, z_it_d;
    logic [PH_W-1:0]        ang_d, phase_d;

    atan_rom u_atan_rom (
        .idx_i  (cnt_q),
        .atan_o (atan_w)
    );

    assign atan_ext = $signed({4'b0, atan_w});
    // Both shifts take the pre-update registers, so x and y move together.
    assign x_sh     = x_q >>> cnt_q;
    assign y_sh     = y_q >>> cnt_q;

    always_comb begin
        x_it_d = x_q;
        y_it_d = y_q;
        z_it_d = z_q;
        if (!y_q[DP_W-1]) begin
            x_it_d = x_q + y_sh;
            y_it_d = y_q - x_sh;
            z_it_d = z_q + atan_ext;
        end else begin
            x_it_d = x_q - y_sh;
            y_it_d = y_q + x_sh;
            z_it_d = z_q - atan_ext;
        end
    end

    // Residual rotation can leave z a few LSB outside the first quadrant;
    // clamp before unfolding so the quadrant arithmetic never wraps.
    always_comb begin
        ang_d = '0;
        if (z_q < 0)
            ang_d = '0;
        else if (z_q > 20'sd16384)
            ang_d = 16'd16384;
        else
            ang_d = z_q[PH_W-1:0];

        case ({qx_q, qy_q})
            2'b00:   phase_d = ang_d;
            2'b10:   phase_d = 16'd32768 - ang_d;
            2'b11:   phase_d = 16'd32768 + ang_d;
            default: phase_d = 16'd0 - ang_d;     // 65536 - a, mod 2^16
        endcase

        // A zero vector never rotates, so z would sum the whole table;
        // the magnitude being zero identifies that case.
        if (x_q == '0)
            phase_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            qx_q    <= 1'b0;
            qy_q    <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            phase_q <= '0;
            mag_q   <= '0;
        end else begin
            fin_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // busy stays up through the finish cycle, then drops
                    // unless a new request arrives in that same cycle.
                    busy_q <= en;
                    if (en) begin
                        x_q     <= DP_W'(x_in);
                        y_q     <= DP_W'(y_in);
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    qx_q    <= x_q[DP_W-1];
                    qy_q    <= y_q[DP_W-1];
                    x_q     <= sat_abs(x_q);
                    y_q     <= sat_abs(y_q);
                    z_q     <= '0;
                    cnt_q   <= '0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    x_q   <= x_it_d;
                    y_q   <= y_it_d;
                    z_q   <= z_it_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(ITER - 1))
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    phase_q <= phase_d;
                    mag_q   <= x_q[MAG_W-1:0];
                    fin_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign finish_phase = fin_q;
    assign phase_out    = phase_q;
    assign mag_out      = mag_q;

endmodule

// File: tb/tb_phase_extract.sv
module tb_phase_extract;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic               en    = 1'b0;
    logic signed [16:0] x_in  = '0;
    logic signed [16:0] y_in  = '0;
    logic               busy, finish_phase;
    logic [15:0]        phase_out;
    logic [17:0]        mag_out;

    int n_vec = 0;
    int n_bad = 0;

    phase_extract #(.ITER(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .x_in         (x_in),
        .y_in         (y_in),
        .busy         (busy),
        .finish_phase (finish_phase),
        .phase_out    (phase_out),
        .mag_out      (mag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [16:0] x;
        logic signed [16:0] y;
        int                 ph;
        int                 ph_tol;
        int                 mag;
        int                 mag_tol;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp, input int tol);
        n_vec++;
        if (act - exp > tol || exp - act > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    // Phase compare on the circle: 65535 is 1 LSB away from 0.
    task automatic chk_ph(input string name, input logic [15:0] act, input int exp, input int tol);
        logic [15:0]        e16;
        logic signed [15:0] d;
        int                 di;
        e16 = 16'(exp);
        d   = $signed(act - e16);
        di  = int'(d);
        n_vec++;
        if (di > tol || -di > tol) begin
            n_bad++;
            $display("FAIL %s: got phase %0d, want %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    // Issue one request and wait (bounded) for its result.
    task automatic run(input logic signed [16:0] x, input logic signed [16:0] y,
                       output int ph, output int mag, output int lat,
                       output int busy_ok, output int fin_after);
        @(negedge clk);
        x_in = x; y_in = y; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        lat = 0;
        busy_ok = busy ? 1 : 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (!busy) busy_ok = 0;
            if (finish_phase) break;
        end
        ph  = int'(phase_out);
        mag = int'(mag_out);
        @(posedge clk); #1;
        fin_after = finish_phase ? 1 : 0;
    endtask

    initial begin
        int ph, mag, lat, bok, fa;
        int nfin, fin_at, gap;

        tbl[0]  = '{17'sd19898,      17'sd0,      0,     3, 32767,  35};
        tbl[1]  = '{17'sd0,          17'sd19898,  16384, 3, 32767,  35};
        tbl[2]  = '{-17'sd19898,     17'sd0,      32768, 3, 32767,  35};
        tbl[3]  = '{17'sd0,          -17'sd19898, 49152, 3, 32767,  35};
        tbl[4]  = '{17'sd14070,      17'sd14070,  8192,  3, 32767,  35};
        tbl[5]  = '{-17'sd14070,     -17'sd14070, 40960, 3, 32767,  35};
        tbl[6]  = '{17'sd14070,      -17'sd14070, 57344, 3, 32767,  35};
        tbl[7]  = '{-17'sd14070,     17'sd14070,  24576, 3, 32767,  35};
        tbl[8]  = '{17'sd0,          17'sd0,      0,     0, 0,      0};
        tbl[9]  = '{17'h10000,       17'sd0,      32768, 3, 107920, 110};
        tbl[10] = '{17'sd3000,       -17'sd4000,  55864, 3, 8234,   10};

        // reset state
        #2 rst_n = 1'b0;
        #10;
        chk("rst_busy",   int'(busy),         0, 0);
        chk("rst_finish", int'(finish_phase), 0, 0);
        chk("rst_phase",  int'(phase_out),    0, 0);
        chk("rst_mag",    int'(mag_out),      0, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run(tbl[i].x, tbl[i].y, ph, mag, lat, bok, fa);
            chk($sformatf("v%0d_latency", i), lat, 18, 0);
            chk($sformatf("v%0d_busy", i), bok, 1, 0);
            chk_ph($sformatf("v%0d_phase", i), 16'(ph), tbl[i].ph, tbl[i].ph_tol);
            chk($sformatf("v%0d_mag", i), mag, tbl[i].mag, tbl[i].mag_tol);
            chk($sformatf("v%0d_single_pulse", i), fa, 0, 0);
        end

        // en while busy (cycles +1, +5) and during DONE (+18) is dropped
        @(negedge clk);
        x_in = 17'sd19898; y_in = 17'sd0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        x_in = 17'sd0; y_in = 17'sd19898;
        nfin = 0; fin_at = 0; gap = 0;
        for (int k = 1; k <= 45; k++) begin
            en = (k == 1 || k == 5 || k == 18);
            @(posedge clk); #1;
            if (finish_phase) begin
                nfin++;
                if (fin_at == 0) fin_at = k;
            end
            if (fin_at == 0 && !busy) gap = 1;
            if (k == fin_at && !busy) gap = 1;
        end
        en = 1'b0;
        chk("ign_finish_count", nfin, 1, 0);
        chk("ign_finish_cycle", fin_at, 18, 0);
        chk("ign_busy_gap", gap, 0, 0);
        chk_ph("ign_phase", phase_out, 0, 3);
        chk("ign_busy_end", int'(busy), 0, 0);

        // known non-zero result before the abort
        run(17'sd0, 17'sd19898, ph, mag, lat, bok, fa);
        chk_ph("pre_abort_phase", 16'(ph), 16384, 3);

        // abort during iteration 8
        @(negedge clk);
        x_in = 17'sd14070; y_in = 17'sd14070; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy",   int'(busy),         0, 0);
        chk("abort_finish", int'(finish_phase), 0, 0);
        chk("abort_phase",  int'(phase_out),    0, 0);
        chk("abort_mag",    int'(mag_out),      0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nfin = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (finish_phase) nfin++;
        end
        chk("abort_no_finish", nfin, 0, 0);

        run(-17'sd14070, 17'sd14070, ph, mag, lat, bok, fa);
        chk("post_abort_latency", lat, 18, 0);
        chk_ph("post_abort_phase", 16'(ph), 24576, 3);
        chk("post_abort_mag", mag, 32767, 35);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
